dual_core_scheduler: RTL

DUAL_CORE_SCHEDULER -- requirements
Module: dual_core_scheduler

---
 rtl/dual_core_scheduler_if.sv | 21 ++
 rtl/dual_core_scheduler.sv | 75 +++++++
 2 files changed

// File: rtl/dual_core_scheduler_if.sv
// dual_core_scheduler_if: start/sum/output handshakes between the scheduler, its two cores and the shared output port
interface dual_core_scheduler_if #(parameter int SUM_W = 24);
  logic start, core0_done, core1_done, core0_sum_valid, core1_sum_valid;
  logic [SUM_W-1:0] core0_sum, core1_sum;
  logic core0_out_req, core1_out_req, out_ready;
  logic core0_start, core1_start, sum_ack, sum_total_valid;
  logic [SUM_W:0] sum_total;
  logic core0_out_gnt, core1_out_gnt, busy, done;
  modport master (
    output start, core0_done, core1_done, core0_sum_valid, core1_sum_valid, core0_sum, core1_sum,
           core0_out_req, core1_out_req, out_ready,
    input  core0_start, core1_start, sum_ack, sum_total, sum_total_valid, core0_out_gnt, core1_out_gnt,
           busy, done
  );
  modport slave (
    input  start, core0_done, core1_done, core0_sum_valid, core1_sum_valid, core0_sum, core1_sum,
           core0_out_req, core1_out_req, out_ready,
    output core0_start, core1_start, sum_ack, sum_total, sum_total_valid, core0_out_gnt, core1_out_gnt,
           busy, done
  );
endinterface

// File: rtl/dual_core_scheduler.sv
// dual_core_scheduler: launches two cores, merges their partial sums and time-shares one output port
// between them, alternating which core is served first on each run.
module dual_core_scheduler #(
  parameter int ROWS  = 8,
  parameter int SUM_W = 24
) (
  input logic clk,
  input logic reset,
  dual_core_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_SUM, SUM_BCAST, OUT_FIRST, OUT_SECOND, WAIT_IDLE} state_t;
  state_t state_q;
  logic pri_q, start_q, ack_q, tvalid_q, done_q;
  logic [3:0] cnt_q;
  logic [SUM_W:0] sum_q;
  logic out_phase, serve1, beat, last;
  assign out_phase = state_q == OUT_FIRST || state_q == OUT_SECOND;
  assign serve1 = (state_q == OUT_SECOND) ^ pri_q;
  assign beat = out_phase && bus.out_ready && (serve1 ? bus.core1_out_req : bus.core0_out_req);
  assign last = cnt_q == 4'(ROWS - 1);
  assign bus.core0_out_gnt = out_phase && !serve1;
  assign bus.core1_out_gnt = out_phase && serve1;
  assign bus.core0_start = start_q;
  assign bus.core1_start = start_q;
  assign bus.sum_ack = ack_q;
  assign bus.sum_total = sum_q;
  assign bus.sum_total_valid = tvalid_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  // Pulse registers are set on the edge that enters the state they announce.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pri_q <= 1'b0;
      cnt_q <= '0;
      sum_q <= '0;
      start_q <= 1'b0;
      ack_q <= 1'b0;
      tvalid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      ack_q <= 1'b0;
      tvalid_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start && bus.core0_done && bus.core1_done) begin
          state_q <= LAUNCH;
          start_q <= 1'b1;
        end
        LAUNCH: state_q <= WAIT_SUM;
        WAIT_SUM: if (bus.core0_sum_valid && bus.core1_sum_valid) begin
          sum_q <= {1'b0, bus.core0_sum} + {1'b0, bus.core1_sum};
          ack_q <= 1'b1;
          tvalid_q <= 1'b1;
          state_q <= SUM_BCAST;
        end
        SUM_BCAST: begin
          cnt_q <= '0;
          state_q <= OUT_FIRST;
        end
        OUT_FIRST, OUT_SECOND: if (beat) begin
          cnt_q <= last ? 4'd0 : cnt_q + 4'd1;
          if (last) state_q <= state_q == OUT_FIRST ? OUT_SECOND : WAIT_IDLE;
          if (last && state_q == OUT_SECOND) pri_q <= !pri_q;
        end
        WAIT_IDLE: if (bus.core0_done && bus.core1_done) begin
          done_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
